ifetch_mem_port: RTL



---
 rtl/ifetch_mem_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ifetch_mem_port.sv
// rtl/ifetch_mem_port.sv - icache miss responder fetching 2/4 instruction bytes over a byte-wide RAM bus
// Optional statistics counters are compiled in when IFETCH_STAT_EN is defined.
module ifetch_mem_port #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  need_flush_in,
    input  logic                  miss_in,
    input  logic [ADDR_WIDTH-1:0] miss_addr_in,
    output logic                  busy_out,
    output logic                  valid_out,
    output logic [31:0]           instr_out,
    output logic                  ram_req_out,
    input  logic                  ram_gnt_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    input  logic [7:0]            ram_din_in
`ifdef IFETCH_STAT_EN
    ,
    output logic [31:0]           fetch_cnt_out,
    output logic [15:0]           flush_abort_cnt_out
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        FETCH,
        DONE
    } state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic                  len32;
    logic [ADDR_WIDTH-1:0] base;
    logic [23:0]           asm_word;

    // cnt tracks the FETCH cycle: 1 = A0 (base on the bus), data lags the address by one cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            len32        <= 1'b0;
            base         <= '0;
            asm_word     <= 24'd0;
            busy_out     <= 1'b0;
            valid_out    <= 1'b0;
            instr_out    <= 32'd0;
            ram_req_out  <= 1'b0;
            ram_addr_out <= '0;
        end else if (rdy_in) begin
            valid_out <= 1'b0;
            if (need_flush_in) begin
                state       <= IDLE;
                cnt         <= 3'd0;
                len32       <= 1'b0;
                busy_out    <= 1'b0;
                ram_req_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (miss_in) begin
                            base        <= miss_addr_in;
                            busy_out    <= 1'b1;
                            ram_req_out <= 1'b1;
                            state       <= WAIT_GNT;
                        end
                    end
                    WAIT_GNT: begin
                        if (ram_gnt_in) begin
                            ram_addr_out <= base;
                            cnt          <= 3'd1;
                            len32        <= 1'b0;
                            state        <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (!ram_gnt_in) begin
                            // Lost the bus: bytes gathered so far are stale, start over.
                            state <= WAIT_GNT;
                            cnt   <= 3'd0;
                            len32 <= 1'b0;
                        end else begin
                            case (cnt)
                                3'd1: begin
                                    ram_addr_out <= base + ADDR_WIDTH'(1);
                                    cnt          <= 3'd2;
                                end
                                3'd2: begin
                                    asm_word[7:0] <= ram_din_in;
                                    len32         <= (ram_din_in[1:0] == 2'b11);
                                    if (ram_din_in[1:0] == 2'b11) begin
                                        ram_addr_out <= base + ADDR_WIDTH'(2);
                                    end
                                    cnt <= 3'd3;
                                end
                                3'd3: begin
                                    if (!len32) begin
                                        instr_out   <= {16'h0000, ram_din_in, asm_word[7:0]};
                                        valid_out   <= 1'b1;
                                        ram_req_out <= 1'b0;
                                        cnt         <= 3'd0;
                                        state       <= DONE;
                                    end else begin
                                        asm_word[15:8] <= ram_din_in;
                                        ram_addr_out   <= base + ADDR_WIDTH'(3);
                                        cnt            <= 3'd4;
                                    end
                                end
                                3'd4: begin
                                    asm_word[23:16] <= ram_din_in;
                                    cnt             <= 3'd5;
                                end
                                3'd5: begin
                                    instr_out   <= {ram_din_in, asm_word};
                                    valid_out   <= 1'b1;
                                    ram_req_out <= 1'b0;
                                    cnt         <= 3'd0;
                                    state       <= DONE;
                                end
                                default: cnt <= 3'd0;
                            endcase
                        end
                    end
                    DONE: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef IFETCH_STAT_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fetch_cnt_out       <= 32'd0;
            flush_abort_cnt_out <= 16'd0;
        end else if (rdy_in) begin
            if (valid_out) begin
                fetch_cnt_out <= fetch_cnt_out + 32'd1;
            end
            if (need_flush_in && (state != IDLE) && (flush_abort_cnt_out != 16'hFFFF)) begin
                flush_abort_cnt_out <= flush_abort_cnt_out + 16'd1;
            end
        end
    end
`endif

endmodule
